// File: rtl/port_stats_agg_if.sv
// Register-table write port: one outstanding write request, completed by a
// single-cycle acknowledge from the register-table arbiter.
interface port_stats_agg_if;
    logic [6:0]  port_addr;
    logic [15:0] port_din;
    logic        port_req;
    logic        port_ack;

    modport master (output port_addr, output port_din, output port_req, input port_ack);
    modport slave  (input port_addr, input port_din, input port_req, output port_ack);
endinterface

// File: rtl/port_stats_agg.sv
// Per-port RX/TX frame statistics: drains status FIFOs into saturating live
// counters and, on every window tick, reports a 16-bit snapshot to the register table.
module port_stats_agg #(
    parameter int         NPORT    = 4,
    parameter int         CNT_W    = 32,
    parameter logic [6:0] REG_BASE = 7'h10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  time_rst,
    port_stats_agg_if.master      reg_if,
    output logic [NPORT-1:0]      rx_status_fifo_rd,
    input  logic [16*NPORT-1:0]   rx_status_fifo_dout,
    input  logic [NPORT-1:0]      rx_status_fifo_empty,
    output logic [NPORT-1:0]      tx_status_fifo_rd,
    input  logic [16*NPORT-1:0]   tx_status_fifo_dout,
    input  logic [NPORT-1:0]      tx_status_fifo_empty,
    output logic                  busy,
    output logic                  overrun
);
    typedef enum logic [1:0] {D_IDLE, D_WAIT, D_CAPT} drain_e;
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WAIT_ACK, S_GAP} seq_e;

    localparam int NWORD = 4 * NPORT;
    localparam int IW    = $clog2(NWORD);

    function automatic drain_e next_drain(input drain_e st, input logic empty);
        case (st)
            D_IDLE:  return empty ? D_IDLE : D_WAIT;
            D_WAIT:  return D_CAPT;
            default: return D_IDLE;
        endcase
    endfunction

    // A capture coinciding with the window clear seeds the new window.
    function automatic logic [CNT_W-1:0] accum(input logic [CNT_W-1:0] cur,
                                               input logic [CNT_W-1:0] inc,
                                               input logic capt, input logic clr);
        logic [CNT_W:0] sum;
        sum = {1'b0, cur} + {1'b0, inc};
        if (clr)   return capt ? inc : '0;
        if (!capt) return cur;
        return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    endfunction

    function automatic logic [15:0] sat16(input logic [CNT_W-1:0] v);
        logic [CNT_W+15:0] w;
        w = {16'h0000, v};
        return (w[CNT_W+15:16] != '0) ? 16'hFFFF : w[15:0];
    endfunction

    logic [NPORT-1:0][CNT_W-1:0] rx_bytes_w, tx_bytes_w, rx_frames_w, rx_crc_w;

    seq_e            seq_q, seq_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [6:0]      addr_q, addr_d;
    logic [15:0]     din_q, din_d;
    logic            req_q, req_d;
    logic            busy_q, busy_d;
    logic            ovr_q, ovr_d;
    logic [15:0]     snap_q [NWORD];
    logic [15:0]     snap_d [NWORD];
    logic            accept;

    assign accept = time_rst && !busy_q;

    genvar gi;
    for (gi = 0; gi < NPORT; gi++) begin : g_port
        drain_e           rx_st_q, rx_st_d, tx_st_q, tx_st_d;
        logic [CNT_W-1:0] rx_bytes_q, rx_bytes_d, rx_frames_q, rx_frames_d;
        logic [CNT_W-1:0] rx_crc_q, rx_crc_d, tx_bytes_q, tx_bytes_d;
        logic [15:0]      rx_word, tx_word;
        logic             rx_capt, tx_capt;
        logic             unused_bits;

        assign rx_word = rx_status_fifo_dout[16*gi +: 16];
        assign tx_word = tx_status_fifo_dout[16*gi +: 16];
        assign rx_capt = (rx_st_q == D_CAPT);
        assign tx_capt = (tx_st_q == D_CAPT);
        assign rx_status_fifo_rd[gi] = (rx_st_q == D_IDLE) && !rx_status_fifo_empty[gi];
        assign tx_status_fifo_rd[gi] = (tx_st_q == D_IDLE) && !tx_status_fifo_empty[gi];
        assign unused_bits = ^{rx_word[14:12], tx_word[15:12]};

        always_comb begin
            rx_st_d     = next_drain(rx_st_q, rx_status_fifo_empty[gi]);
            tx_st_d     = next_drain(tx_st_q, tx_status_fifo_empty[gi]);
            rx_bytes_d  = accum(rx_bytes_q, CNT_W'(rx_word[11:0]), rx_capt, time_rst);
            rx_frames_d = accum(rx_frames_q, CNT_W'(1), rx_capt, time_rst);
            rx_crc_d    = accum(rx_crc_q, CNT_W'(rx_word[15]), rx_capt, time_rst);
            tx_bytes_d  = accum(tx_bytes_q, CNT_W'(tx_word[11:0]), tx_capt, time_rst);
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                rx_st_q     <= D_IDLE;
                tx_st_q     <= D_IDLE;
                rx_bytes_q  <= '0;
                rx_frames_q <= '0;
                rx_crc_q    <= '0;
                tx_bytes_q  <= '0;
            end else begin
                rx_st_q     <= rx_st_d;
                tx_st_q     <= tx_st_d;
                rx_bytes_q  <= rx_bytes_d;
                rx_frames_q <= rx_frames_d;
                rx_crc_q    <= rx_crc_d;
                tx_bytes_q  <= tx_bytes_d;
            end
        end

        assign rx_bytes_w[gi]  = rx_bytes_q;
        assign tx_bytes_w[gi]  = tx_bytes_q;
        assign rx_frames_w[gi] = rx_frames_q;
        assign rx_crc_w[gi]    = rx_crc_q;
    end

    // Snapshot takes the pre-clear live values; a tick while reporting leaves it untouched.
    always_comb begin
        for (int i = 0; i < NWORD; i++) snap_d[i] = snap_q[i];
        if (accept) begin
            for (int p = 0; p < NPORT; p++) begin
                snap_d[4*p]     = sat16(rx_bytes_w[p]);
                snap_d[4*p + 1] = sat16(tx_bytes_w[p]);
                snap_d[4*p + 2] = sat16(rx_frames_w[p]);
                snap_d[4*p + 3] = sat16(rx_crc_w[p]);
            end
        end
    end

    always_comb begin
        seq_d  = seq_q;
        idx_d  = idx_q;
        addr_d = addr_q;
        din_d  = din_q;
        req_d  = req_q;
        busy_d = busy_q;
        ovr_d  = ovr_q | (time_rst && busy_q);
        case (seq_q)
            S_IDLE: if (accept) begin
                seq_d  = S_SETUP;
                idx_d  = '0;
                req_d  = 1'b1;
                busy_d = 1'b1;
            end
            S_SETUP: seq_d = S_WAIT_ACK;
            S_WAIT_ACK: if (reg_if.port_ack) begin
                req_d = 1'b0;
                seq_d = S_GAP;
            end
            default: if (idx_q == IW'(NWORD - 1)) begin
                seq_d  = S_IDLE;
                busy_d = 1'b0;
            end else begin
                idx_d = idx_q + 1'b1;
                seq_d = S_SETUP;
                req_d = 1'b1;
            end
        endcase
        // Address and data are latched as the request rises and held until acknowledged.
        if (req_d && !req_q) begin
            addr_d = REG_BASE + 7'(idx_d);
            din_d  = snap_d[idx_d];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seq_q  <= S_IDLE;
            idx_q  <= '0;
            addr_q <= '0;
            din_q  <= '0;
            req_q  <= 1'b0;
            busy_q <= 1'b0;
            ovr_q  <= 1'b0;
            for (int i = 0; i < NWORD; i++) snap_q[i] <= '0;
        end else begin
            seq_q  <= seq_d;
            idx_q  <= idx_d;
            addr_q <= addr_d;
            din_q  <= din_d;
            req_q  <= req_d;
            busy_q <= busy_d;
            ovr_q  <= ovr_d;
            for (int i = 0; i < NWORD; i++) snap_q[i] <= snap_d[i];
        end
    end

    assign reg_if.port_addr = addr_q;
    assign reg_if.port_din  = din_q;
    assign reg_if.port_req  = req_q;
    assign busy             = busy_q;
    assign overrun          = ovr_q;
endmodule

// File: tb/tb_port_stats_agg.sv
// Bench for port_stats_agg: FIFO and register-table models, a window-level
// statistics reference, and a 16-bit-counter twin fed identical traffic.
`timescale 1ns/1ps
module tb_port_stats_agg;
    localparam int         NPORT    = 4;
    localparam int         NWORD    = 4 * NPORT;
    localparam logic [6:0] REG_BASE = 7'h10;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 time_rst = 1'b0;
    logic                 port_ack = 1'b0;
    logic [NPORT-1:0]     rx_rd, tx_rd, unused_rx_rd2, unused_tx_rd2;
    logic [NPORT-1:0]     rx_empty = '1;
    logic [NPORT-1:0]     tx_empty = '1;
    logic [16*NPORT-1:0]  rx_dout = '0;
    logic [16*NPORT-1:0]  tx_dout = '0;
    logic                 busy, overrun, unused_busy2, unused_overrun2;

    port_stats_agg_if bus1();
    port_stats_agg_if bus2();
    assign bus1.port_ack = port_ack;
    assign bus2.port_ack = port_ack;

    port_stats_agg #(.NPORT(NPORT), .CNT_W(32), .REG_BASE(REG_BASE)) dut (
        .clk(clk), .rst(rst), .time_rst(time_rst), .reg_if(bus1),
        .rx_status_fifo_rd(rx_rd), .rx_status_fifo_dout(rx_dout), .rx_status_fifo_empty(rx_empty),
        .tx_status_fifo_rd(tx_rd), .tx_status_fifo_dout(tx_dout), .tx_status_fifo_empty(tx_empty),
        .busy(busy), .overrun(overrun));

    port_stats_agg #(.NPORT(NPORT), .CNT_W(16), .REG_BASE(REG_BASE)) dut16 (
        .clk(clk), .rst(rst), .time_rst(time_rst), .reg_if(bus2),
        .rx_status_fifo_rd(unused_rx_rd2), .rx_status_fifo_dout(rx_dout), .rx_status_fifo_empty(rx_empty),
        .tx_status_fifo_rd(unused_tx_rd2), .tx_status_fifo_dout(tx_dout), .tx_status_fifo_empty(tx_empty),
        .busy(unused_busy2), .overrun(unused_overrun2));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Status FIFO models: one-entry-per-pop, data presented the cycle after the read strobe.
    logic [15:0]      rx_mem [NPORT][256];
    logic [15:0]      tx_mem [NPORT][256];
    int               rx_wp [NPORT] = '{default: 0};
    int               rx_rp [NPORT] = '{default: 0};
    int               tx_wp [NPORT] = '{default: 0};
    int               tx_rp [NPORT] = '{default: 0};
    logic [NPORT-1:0] rx_rd_s = '0;
    logic [NPORT-1:0] tx_rd_s = '0;

    always @(negedge clk) begin
        rx_rd_s = rx_rd;
        tx_rd_s = tx_rd;
        for (int p = 0; p < NPORT; p++) begin
            if (rx_rd[p]) check($sformatf("rx%0d_rd_while_empty", p), rx_empty[p], 1'b0);
            if (tx_rd[p]) check($sformatf("tx%0d_rd_while_empty", p), tx_empty[p], 1'b0);
        end
    end

    always @(posedge clk) begin
        #1;
        for (int p = 0; p < NPORT; p++) begin
            if (rx_rd_s[p]) begin
                rx_dout[16*p +: 16] = rx_mem[p][8'(rx_rp[p])];
                rx_rp[p]++;
            end
            if (tx_rd_s[p]) begin
                tx_dout[16*p +: 16] = tx_mem[p][8'(tx_rp[p])];
                tx_rp[p]++;
            end
            rx_empty[p] = (rx_wp[p] == rx_rp[p]);
            tx_empty[p] = (tx_wp[p] == tx_rp[p]);
        end
        rx_rd_s = '0;
        tx_rd_s = '0;
    end

    // Register-table responder: ack ack_delay cycles after the request rises,
    // optionally with a spurious pulse in the first request cycle.
    int ack_delay = 1;
    bit ack_in_setup = 1'b0;
    int req_cnt = 0;

    always @(posedge clk) begin
        #1;
        port_ack = 1'b0;
        if (bus1.port_req) begin
            req_cnt++;
            if (req_cnt == ack_delay + 1) port_ack = 1'b1;
            if (req_cnt == 1 && ack_in_setup) port_ack = 1'b1;
        end else begin
            req_cnt = 0;
        end
    end

    // Write monitor: handshake shape and the sequence of completed writes.
    logic [22:0] wq1 [$];
    logic [22:0] wq2 [$];
    int          wr_in_rep = 0;
    int          after_ack = 0;
    logic        prev_req = 1'b0;
    logic [6:0]  lat_addr = '0;
    logic [15:0] lat_din = '0;

    always @(negedge clk) begin
        if (bus1.port_req && prev_req) begin
            check("req_addr_stable", bus1.port_addr, lat_addr);
            check("req_din_stable", bus1.port_din, lat_din);
        end
        lat_addr = bus1.port_addr;
        lat_din  = bus1.port_din;
        if (after_ack == 1) begin
            check("req_low_after_ack", bus1.port_req, 1'b0);
            after_ack = 2;
        end else if (after_ack == 2) begin
            check("req_after_gap", bus1.port_req, wr_in_rep < NWORD);
            check("busy_after_gap", busy, wr_in_rep < NWORD);
            after_ack = 0;
        end
        if (port_ack && bus1.port_req && req_cnt >= 2) begin
            wq1.push_back({bus1.port_addr, bus1.port_din});
            if (bus2.port_req) wq2.push_back({bus2.port_addr, bus2.port_din});
            wr_in_rep++;
            after_ack = 1;
        end
        prev_req = bus1.port_req;
    end

    // Reference model: per-window sums; nxt_* holds entries captured on a tick cycle.
    int unsigned win_rxb [NPORT], win_txb [NPORT], win_rxf [NPORT], win_crc [NPORT];
    int unsigned nxt_rxb [NPORT], nxt_txb [NPORT], nxt_rxf [NPORT], nxt_crc [NPORT];
    logic [15:0] exp_rep [NWORD];

    function automatic logic [15:0] sat16m(input int unsigned v);
        if (v > 32'd65535) return 16'hFFFF;
        return 16'(v);
    endfunction

    task automatic model_clear();
        for (int p = 0; p < NPORT; p++) begin
            win_rxb[p] = 0; win_txb[p] = 0; win_rxf[p] = 0; win_crc[p] = 0;
            nxt_rxb[p] = 0; nxt_txb[p] = 0; nxt_rxf[p] = 0; nxt_crc[p] = 0;
        end
    endtask

    task automatic push_rx(input int p, input int len, input bit crc, input bit nxt);
        rx_mem[p][8'(rx_wp[p])] = {crc, 3'($urandom), 12'(len)};
        rx_wp[p]++;
        if (nxt) begin
            nxt_rxb[p] += len; nxt_rxf[p] += 1; nxt_crc[p] += crc;
        end else begin
            win_rxb[p] += len; win_rxf[p] += 1; win_crc[p] += crc;
        end
    endtask

    task automatic push_tx(input int p, input int len);
        tx_mem[p][8'(tx_wp[p])] = {4'($urandom), 12'(len)};
        tx_wp[p]++;
        win_txb[p] += len;
    endtask

    task automatic push_random(input int maxn);
        for (int p = 0; p < NPORT; p++) begin
            repeat ($urandom_range(0, maxn)) push_rx(p, $urandom_range(0, 4095), 1'($urandom_range(0, 1)), 1'b0);
            repeat ($urandom_range(0, maxn)) push_tx(p, $urandom_range(0, 4095));
        end
    endtask

    task automatic tick(input bit exp_accept);
        if (exp_accept) wr_in_rep = 0;
        @(posedge clk); #2 time_rst = 1'b1;
        @(posedge clk); #2 time_rst = 1'b0;
        if (exp_accept) begin
            for (int p = 0; p < NPORT; p++) begin
                exp_rep[4*p]     = sat16m(win_rxb[p]);
                exp_rep[4*p + 1] = sat16m(win_txb[p]);
                exp_rep[4*p + 2] = sat16m(win_rxf[p]);
                exp_rep[4*p + 3] = sat16m(win_crc[p]);
            end
        end
        for (int p = 0; p < NPORT; p++) begin
            win_rxb[p] = nxt_rxb[p]; win_txb[p] = nxt_txb[p];
            win_rxf[p] = nxt_rxf[p]; win_crc[p] = nxt_crc[p];
            nxt_rxb[p] = 0; nxt_txb[p] = 0; nxt_rxf[p] = 0; nxt_crc[p] = 0;
        end
        @(negedge clk);
        if (exp_accept) begin
            check("req_rise_after_tick", bus1.port_req, 1'b1);
            check("busy_rise_after_tick", busy, 1'b1);
        end else begin
            check("overrun_set", overrun, 1'b1);
        end
    endtask

    task automatic wait_report(input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done_in_budget"}, n < 3000, 1'b1);
        check({name, "_writes"}, wq1.size(), NWORD);
        check({name, "_writes_cnt16"}, wq2.size(), NWORD);
        for (int i = 0; i < NWORD; i++) begin
            if (i < wq1.size()) begin
                check($sformatf("%s_w%0d_addr", name, i), wq1[i][22:16], REG_BASE + 7'(i));
                check($sformatf("%s_w%0d_data", name, i), wq1[i][15:0], exp_rep[i]);
            end
            if (i < wq2.size()) begin
                check($sformatf("%s_w%0d_addr_cnt16", name, i), wq2[i][22:16], REG_BASE + 7'(i));
                check($sformatf("%s_w%0d_data_cnt16", name, i), wq2[i][15:0], exp_rep[i]);
            end
        end
        wq1.delete();
        wq2.delete();
        $display("report %s: %0d writes checked", name, NWORD);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_port_addr", bus1.port_addr, 7'h00);
        check("rst_port_din", bus1.port_din, 16'h0000);
        check("rst_port_req", bus1.port_req, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_rx_rd", rx_rd, '0);
        check("rst_tx_rd", tx_rd, '0);
        @(posedge clk); #2 rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check("idle_no_req", bus1.port_req, 1'b0);
        end

        // Port 1 RX: 100, 200 with CRC error, 64.
        ack_delay = 1;
        @(posedge clk); #2;
        push_rx(1, 100, 1'b0, 1'b0);
        push_rx(1, 200, 1'b1, 1'b0);
        push_rx(1, 64, 1'b0, 1'b0);
        repeat (15) @(posedge clk);
        tick(1'b1);
        wait_report("port1_rx");

        // Slow acknowledge with random traffic on all ports.
        ack_delay = 5;
        @(posedge clk); #2;
        push_random(6);
        repeat (30) @(posedge clk);
        tick(1'b1);
        wait_report("ack_delay5");

        // Port 0 TX 20 x 4000 bytes saturates the report; spurious ack in SETUP.
        ack_delay = 3;
        ack_in_setup = 1'b1;
        @(posedge clk); #2;
        for (int i = 0; i < 20; i++) push_tx(0, 4000);
        push_random(4);
        repeat (75) @(posedge clk);
        tick(1'b1);
        wait_report("tx_saturate");
        ack_in_setup = 1'b0;

        // Capture lands exactly on the tick cycle: excluded now, reported next window.
        ack_delay = 1;
        repeat (5) @(posedge clk);
        @(posedge clk); #2;
        push_rx(2, 50, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        tick(1'b1);
        wait_report("coincident_cur");
        repeat (5) @(posedge clk);
        tick(1'b1);
        wait_report("coincident_next");

        // Tick while reporting: overrun, snapshot kept, intervening traffic lost.
        ack_delay = 3;
        @(posedge clk); #2;
        push_random(4);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("overrun_clear_before", overrun, 1'b0);
        tick(1'b1);
        repeat (10) @(posedge clk);
        #2 push_random(3);
        repeat (15) @(posedge clk);
        tick(1'b0);
        wait_report("overrun_kept");
        @(posedge clk); #2;
        push_random(4);
        repeat (20) @(posedge clk);
        tick(1'b1);
        wait_report("after_overrun");
        check("overrun_sticky", overrun, 1'b1);

        // Randomised windows with varying acknowledge latency.
        for (int w = 0; w < 3; w++) begin
            ack_delay = $urandom_range(1, 4);
            ack_in_setup = 1'($urandom_range(0, 1)) && (ack_delay >= 2);
            @(posedge clk); #2;
            push_random(6);
            repeat (30) @(posedge clk);
            tick(1'b1);
            wait_report($sformatf("random%0d", w));
        end
        ack_in_setup = 1'b0;

        // Reset while waiting for an acknowledge.
        ack_delay = 20;
        @(posedge clk); #2;
        push_random(3);
        repeat (15) @(posedge clk);
        tick(1'b1);
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        check("midrst_port_req", bus1.port_req, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_overrun", overrun, 1'b0);
        model_clear();
        wq1.delete();
        wq2.delete();
        ack_delay = 1;
        repeat (10) begin
            @(negedge clk);
            check("midrst_no_completion", bus1.port_req, 1'b0);
        end
        tick(1'b1);
        wait_report("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
